// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem req/ack port, one-entry skid buffer and IF/ID register.
// Latency: an ack in REQ with ifid_write=1 lands in IF/ID on the following edge; FULL drains on release.
// Backpressure: ifid_write=0 parks one response in the skid and drops imem_req. FETCH_PERF_EN adds perf counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_write,
    input  logic        ifid_write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    typedef enum logic {S_REQ = 1'b0, S_FULL = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] skid_q, skid_d;
    logic        discard_q, discard_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        flush;
    logic [31:0] seq_pc;

    assign flush  = branch_taken & ifid_write;
    assign seq_pc = req_addr_q + 32'd4;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        skid_d     = skid_q;
        discard_d  = discard_q;
        instr_d    = instr_q;
        pc4_d      = pc4_q;
        valid_d    = valid_q;
        unique case (state_q)
            S_REQ: begin
                if (flush) begin
                    pc_d    = branch_target;
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    // Without an ack the old request stays on the bus; its data is dropped later.
                    if (imem_ack) begin
                        discard_d  = 1'b0;
                        req_addr_d = branch_target;
                    end else begin
                        discard_d  = 1'b1;
                    end
                end else if (imem_ack && discard_q) begin
                    discard_d  = 1'b0;
                    req_addr_d = pc_q;
                    if (ifid_write) begin
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                    end
                end else if (imem_ack && ifid_write) begin
                    instr_d    = imem_rdata;
                    pc4_d      = seq_pc;
                    valid_d    = 1'b1;
                    pc_d       = pc_write ? seq_pc : pc_q;
                    req_addr_d = pc_write ? seq_pc : pc_q;
                end else if (imem_ack) begin
                    skid_d  = imem_rdata;
                    state_d = S_FULL;
                end else if (ifid_write) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
            end
            S_FULL: begin
                if (ifid_write) begin
                    state_d = S_REQ;
                    if (flush) begin
                        pc_d       = branch_target;
                        req_addr_d = branch_target;
                        instr_d    = NOP_INSTR;
                        valid_d    = 1'b0;
                    end else begin
                        instr_d    = skid_q;
                        pc4_d      = seq_pc;
                        valid_d    = 1'b1;
                        pc_d       = pc_write ? seq_pc : pc_q;
                        req_addr_d = pc_write ? seq_pc : pc_q;
                    end
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            skid_q     <= 32'd0;
            discard_q  <= 1'b0;
            instr_q    <= NOP_INSTR;
            pc4_q      <= 32'd0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            skid_q     <= skid_d;
            discard_q  <= discard_d;
            instr_q    <= instr_d;
            pc4_q      <= pc4_d;
            valid_q    <= valid_d;
        end
    end

    // Reset gates the request combinationally so a pending fetch is abandoned at once.
    assign imem_req   = (state_q == S_REQ) & ~rst;
    assign imem_addr  = req_addr_q;
    assign ifid_instr = instr_q;
    assign ifid_pc4   = pc4_q;
    assign ifid_valid = valid_q;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= 32'd0;
            flush_count  <= 32'd0;
        end else begin
            if (!ifid_write) stall_cycles <= stall_cycles + 32'd1;
            if (flush)       flush_count  <= flush_count + 32'd1;
        end
    end
`endif

endmodule
